// File: rtl/xoodyak_hash_ctrl.sv
// ---------------------------------------------------------------------------
// xoodyak_hash_ctrl
//
// Sequencer for the Xoodyak Cyclist hash mode. It owns the 384-bit Xoodoo
// state, absorbs message blocks with the Down padding and domain constants,
// launches the external 12-cycle `permute` engine for every Up, and squeezes
// a 256-bit digest as two 128-bit halves.
//
// Ports
//   eph1            clock
//   reset           synchronous, active-low reset (0 = reset)
//   msg_valid/ready message block handshake
//   msg_data        block bytes, byte i at [8i+7:8i]
//   msg_len         valid bytes 0..16 (larger values clamp to 16)
//   msg_last        final block of the message
//   perm_start      one-cycle start pulse to permute
//   perm_state_in   state to permute (always the state register)
//   perm_state_out  permute result
//   perm_done       permute completion
//   dig_valid/ready digest handshake
//   dig_data        digest, [127:0] first squeeze, [255:128] second squeeze
//   busy            high while squeezing or permuting
//
// Handshake semantics: a transfer happens on a rising edge of eph1 at which
// both valid and ready are 1. The producer holds data stable while valid is
// high and ready is low; ready never depends combinationally on valid.
// While reset is 0 every output is forced to 0.
// ---------------------------------------------------------------------------
module xoodyak_hash_ctrl #(
    parameter int RATE_BYTES = 16
) (
    input  logic         eph1,
    input  logic         reset,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [127:0] msg_data,
    input  logic [4:0]   msg_len,
    input  logic         msg_last,
    output logic         perm_start,
    output logic [383:0] perm_state_in,
    input  logic [383:0] perm_state_out,
    input  logic         perm_done,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] dig_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_ABSORB = 2'd0,
        S_SQZ    = 2'd1,
        S_PERM   = 2'd2,
        S_OUT    = 2'd3
    } fsm_t;

    // Where a finished permutation hands control back to.
    typedef enum logic [1:0] {
        R_RA = 2'd0,   // back to absorbing the next block
        R_RM = 2'd1,   // between the two squeezes
        R_RO = 2'd2    // second squeeze done, present the digest
    } ret_t;

    localparam logic [4:0] RATE_N = 5'(RATE_BYTES);

    logic [383:0] st_q, st_d;
    logic         first_q, first_d;
    fsm_t         fsm_q, fsm_d;
    ret_t         ret_q, ret_d;
    logic         started_q, started_d;
    logic [127:0] dig_lo_q, dig_lo_d;
    logic [127:0] dig_hi_q, dig_hi_d;
    logic [4:0]   msg_n;

    always_ff @(posedge eph1) begin
        if (!reset) begin
            st_q      <= '0;
            first_q   <= 1'b1;
            fsm_q     <= S_ABSORB;
            ret_q     <= R_RA;
            started_q <= 1'b0;
            dig_lo_q  <= '0;
            dig_hi_q  <= '0;
        end else begin
            st_q      <= st_d;
            first_q   <= first_d;
            fsm_q     <= fsm_d;
            ret_q     <= ret_d;
            started_q <= started_d;
            dig_lo_q  <= dig_lo_d;
            dig_hi_q  <= dig_hi_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        first_d   = first_q;
        fsm_d     = fsm_q;
        ret_d     = ret_q;
        started_d = started_q;
        dig_lo_d  = dig_lo_q;
        dig_hi_d  = dig_hi_q;
        msg_n     = (msg_len > RATE_N) ? RATE_N : msg_len;

        case (fsm_q)
            S_ABSORB: begin
                if (msg_valid) begin
                    // Down: XOR the message bytes, then the 0x01 pad right
                    // after them, then the hash-absorb Cd on the first block.
                    for (int i = 0; i < RATE_BYTES; i++) begin
                        if (5'(i) < msg_n) begin
                            st_d[8*i +: 8] = st_q[8*i +: 8] ^ msg_data[8*i +: 8];
                        end
                    end
                    for (int i = 0; i <= RATE_BYTES; i++) begin
                        if (5'(i) == msg_n) begin
                            st_d[8*i +: 8] = st_d[8*i +: 8] ^ 8'h01;
                        end
                    end
                    if (first_q) begin
                        st_d[383:376] = st_d[383:376] ^ 8'h03;
                    end
                    first_d = 1'b0;
                    if (msg_last) begin
                        fsm_d = S_SQZ;
                    end else begin
                        fsm_d = S_PERM;
                        ret_d = R_RA;
                    end
                end
            end

            S_SQZ: begin
                // Cu = 0x40 for the Up that yields the first squeeze block.
                st_d[383:376] = st_q[383:376] ^ 8'h40;
                fsm_d         = S_PERM;
                ret_d         = R_RM;
                started_d     = 1'b0;
            end

            S_PERM: begin
                // The start cycle ignores perm_done so a stale completion
                // from an aborted run cannot be mistaken for this one.
                if (!started_q) begin
                    started_d = 1'b1;
                end else if (perm_done) begin
                    started_d = 1'b0;
                    st_d      = perm_state_out;
                    case (ret_q)
                        R_RA: fsm_d = S_ABSORB;
                        R_RM: begin
                            // Down of the empty string with Cd = 0 before the
                            // second Up; staying in PERM re-arms the start.
                            dig_lo_d   = perm_state_out[127:0];
                            st_d[7:0]  = perm_state_out[7:0] ^ 8'h01;
                            ret_d      = R_RO;
                        end
                        default: begin
                            dig_hi_d = perm_state_out[127:0];
                            fsm_d    = S_OUT;
                        end
                    endcase
                end
            end

            default: begin  // S_OUT
                if (dig_ready) begin
                    st_d    = '0;
                    first_d = 1'b1;
                    fsm_d   = S_ABSORB;
                end
            end
        endcase
    end

    assign msg_ready     = reset & (fsm_q == S_ABSORB);
    assign perm_start    = reset & (fsm_q == S_PERM) & ~started_q;
    assign perm_state_in = reset ? st_q : '0;
    assign dig_valid     = reset & (fsm_q == S_OUT);
    assign dig_data      = reset ? {dig_hi_q, dig_lo_q} : '0;
    assign busy          = reset & ((fsm_q == S_SQZ) | (fsm_q == S_PERM));

endmodule

// File: tb/tb_xoodyak_hash_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xoodyak_hash_ctrl
//
// Directed bench for xoodyak_hash_ctrl. A registered permute stub returns the
// state sampled one cycle after start (optionally XORed with a fixed mask) and
// raises done 12 cycles after start. Expected states and digests are worked
// out by hand from the Down/Up rules of the hash mode.
// ---------------------------------------------------------------------------
module tb_xoodyak_hash_ctrl;

    logic         eph1;
    logic         reset;
    logic         msg_valid;
    logic         msg_ready;
    logic [127:0] msg_data;
    logic [4:0]   msg_len;
    logic         msg_last;
    logic         perm_start;
    logic [383:0] perm_state_in;
    logic [383:0] perm_state_out = '0;
    logic         perm_done = 1'b0;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] dig_data;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int n_starts = 0;
    int s_snap;

    int           pcnt        = 0;
    logic [383:0] samp        = '0;
    logic         stub_xor    = 1'b0;
    logic         inject_done = 1'b0;

    localparam logic [383:0] KX = 384'h5AA5;

    logic [383:0] e1, e2, ea;
    logic [127:0] dd;

    xoodyak_hash_ctrl dut (
        .eph1           (eph1),
        .reset          (reset),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .msg_data       (msg_data),
        .msg_len        (msg_len),
        .msg_last       (msg_last),
        .perm_start     (perm_start),
        .perm_state_in  (perm_state_in),
        .perm_state_out (perm_state_out),
        .perm_done      (perm_done),
        .dig_valid      (dig_valid),
        .dig_ready      (dig_ready),
        .dig_data       (dig_data),
        .busy           (busy)
    );

    // ---------------- clock ----------------
    initial eph1 = 1'b0;
    always #5 eph1 = ~eph1;

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- permute stub ----------------
    // Not cleared by the DUT reset, so an aborted run leaves a stale done.
    always @(posedge eph1) begin
        perm_done <= inject_done;
        if (perm_start) begin
            pcnt <= 1;
        end else if (pcnt != 0) begin
            if (pcnt == 1) samp <= perm_state_in;
            if (pcnt == 11) begin
                perm_done      <= 1'b1;
                perm_state_out <= samp ^ (stub_xor ? KX : 384'h0);
                pcnt           <= 0;
            end else begin
                pcnt <= pcnt + 1;
            end
        end
    end

    always @(posedge eph1) begin
        if (perm_start) n_starts <= n_starts + 1;
    end

    // ---------------- helpers ----------------
    function automatic logic [383:0] sb(input logic [383:0] s, input int idx,
                                        input logic [7:0] v);
        logic [383:0] r;
        r = s;
        r[8*idx +: 8] = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [383:0] obs,
                         input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, 384'(obs), 384'(exp));
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_msg_ready"}, msg_ready, 1'b0);
        check1({tag, "_perm_start"}, perm_start, 1'b0);
        check({tag, "_perm_state_in"}, perm_state_in, 384'h0);
        check1({tag, "_dig_valid"}, dig_valid, 1'b0);
        check({tag, "_dig_data"}, 384'(dig_data), 384'h0);
        check1({tag, "_busy"}, busy, 1'b0);
    endtask

    // Offers one block; returns at the negedge of the cycle after the
    // handshake (cycle T+1).
    task automatic send_block(input logic [127:0] d, input logic [4:0] len,
                              input logic last);
        int n;
        @(negedge eph1);
        msg_data  = d;
        msg_len   = len;
        msg_last  = last;
        msg_valid = 1'b1;
        n = 0;
        while (!msg_ready && n < 40) begin
            @(negedge eph1);
            n++;
        end
        check1("hs_ready", msg_ready, 1'b1);
        @(negedge eph1);
        msg_valid = 1'b0;
        msg_data  = '0;
        msg_len   = '0;
        msg_last  = 1'b0;
    endtask

    // From cycle T+1 after a last block: SQZ, two permutations, digest.
    // Returns at cycle T+28 with the digest presented.
    task automatic run_last(input string tag, input logic [383:0] s1,
                            input logic [383:0] s2, input logic [255:0] dig);
        int s0;
        s0 = n_starts;
        check1({tag, "_sqz_busy"}, busy, 1'b1);
        check1({tag, "_sqz_nostart"}, perm_start, 1'b0);
        @(negedge eph1);                      // T+2
        check1({tag, "_start1"}, perm_start, 1'b1);
        check({tag, "_state1"}, perm_state_in, s1);
        repeat (13) @(negedge eph1);          // T+15
        check1({tag, "_start2"}, perm_start, 1'b1);
        check({tag, "_state2"}, perm_state_in, s2);
        repeat (12) @(negedge eph1);          // T+27
        check1({tag, "_dv_early"}, dig_valid, 1'b0);
        @(negedge eph1);                      // T+28
        check1({tag, "_dv"}, dig_valid, 1'b1);
        check({tag, "_digest"}, 384'(dig_data), 384'(dig));
        check1({tag, "_busy_out"}, busy, 1'b0);
        check({tag, "_starts"}, 384'(n_starts - s0), 384'd2);
    endtask

    task automatic consume(input string tag);
        dig_ready = 1'b1;
        @(negedge eph1);
        dig_ready = 1'b0;
        check1({tag, "_dv_clear"}, dig_valid, 1'b0);
        check1({tag, "_ready_back"}, msg_ready, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset     = 1'b0;
        msg_valid = 1'b0;
        msg_data  = '0;
        msg_len   = '0;
        msg_last  = 1'b0;
        dig_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge eph1);
        check_all_zero("rst");
        reset = 1'b1;
        #1;
        check1("rst_rel_ready", msg_ready, 1'b1);
        check1("rst_rel_busy", busy, 1'b0);
        check("rst_rel_st", perm_state_in, 384'h0);
        check("rst_rel_dig", 384'(dig_data), 384'h0);

        // Empty message, identity permute
        e1 = sb(sb(384'h0, 0, 8'h01), 47, 8'h43);
        e2 = sb(384'h0, 47, 8'h43);
        send_block(128'h0, 5'd0, 1'b1);
        run_last("empty", e1, e2, 256'h1);
        consume("empty");

        // Single 16-byte block, byte i = i, with a 20-cycle digest stall
        dd = 128'h0F0E0D0C0B0A09080706050403020100;
        e1 = '0;
        e1[127:0] = dd;
        e1 = sb(sb(e1, 16, 8'h01), 47, 8'h43);
        e2 = sb(e1, 0, 8'h01);
        send_block(dd, 5'd16, 1'b1);
        run_last("blk16", e1, e2, {128'h0F0E0D0C0B0A09080706050403020101, dd});
        for (int k = 0; k < 20; k++) begin
            @(negedge eph1);
            check1("hold_dv", dig_valid, 1'b1);
            check("hold_dig", 384'(dig_data),
                  384'({128'h0F0E0D0C0B0A09080706050403020101, dd}));
            check1("hold_ready", msg_ready, 1'b0);
        end
        consume("blk16");

        // Two blocks: 3-byte non-last, then 2-byte last
        ea = '0;
        ea[31:0] = 32'h01AABBCC;
        ea = sb(ea, 47, 8'h03);
        send_block(128'hAABBCC, 5'd3, 1'b0);
        check1("two_start", perm_start, 1'b1);
        check("two_state_a", perm_state_in, ea);
        check1("two_ready_t1", msg_ready, 1'b0);
        for (int k = 2; k <= 13; k++) begin
            @(negedge eph1);
            check1("two_ready_low", msg_ready, 1'b0);
        end
        @(negedge eph1);                      // T+14
        check1("two_ready_t14", msg_ready, 1'b1);
        e1 = '0;
        e1[31:0] = 32'h01ABAAEE;
        e1 = sb(e1, 47, 8'h43);
        e2 = sb(e1, 0, 8'hEF);
        send_block(128'h1122, 5'd2, 1'b1);
        check("two_cd_zero", 384'(perm_state_in[383:376]), 384'h03);
        run_last("two", e1, e2, {128'h01ABAAEF, 128'h01ABAAEE});
        consume("two");

        // Non-identity permute: result must really be loaded into the state
        stub_xor = 1'b1;
        e1 = sb(sb(384'h0, 0, 8'h01), 47, 8'h43);
        e2 = sb(sb(sb(384'h0, 0, 8'hA5), 1, 8'h5A), 47, 8'h43);
        send_block(128'h0, 5'd0, 1'b1);
        run_last("xor", e1, e2, {128'h0, 128'h5AA4});
        consume("xor");
        stub_xor = 1'b0;

        // msg_len above the rate clamps to 16 bytes
        dd = {16{8'h11}};
        e1 = '0;
        e1[127:0] = dd;
        e1 = sb(sb(e1, 16, 8'h01), 47, 8'h43);
        e2 = sb(e1, 0, 8'h10);
        send_block(dd, 5'd20, 1'b1);
        run_last("clamp", e1, e2, {{{15{8'h11}}, 8'h10}, dd});
        consume("clamp");

        // Reset in the middle of a permutation
        send_block(128'h77, 5'd1, 1'b0);      // T+1
        check1("rp_start", perm_start, 1'b1);
        repeat (5) @(negedge eph1);           // T+6
        check1("rp_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_all_zero("rp_in_reset");
        @(negedge eph1);                      // T+7
        check_all_zero("rp_in_reset2");
        reset = 1'b1;                         // T+8
        #1;
        check1("rp_ready", msg_ready, 1'b1);
        check("rp_st_clear", perm_state_in, 384'h0);
        check("rp_dig_clear", 384'(dig_data), 384'h0);
        s_snap = n_starts;
        @(negedge eph1);
        inject_done = 1'b1;
        @(negedge eph1);
        inject_done = 1'b0;
        repeat (8) @(negedge eph1);           // stale done from the stub passes here
        check1("rp_stray_ready", msg_ready, 1'b1);
        check1("rp_stray_busy", busy, 1'b0);
        check("rp_stray_nostart", 384'(n_starts - s_snap), 384'd0);
        check("rp_stray_st", perm_state_in, 384'h0);
        e1 = sb(sb(384'h0, 0, 8'h01), 47, 8'h43);
        e2 = sb(384'h0, 47, 8'h43);
        send_block(128'h0, 5'd0, 1'b1);
        run_last("rp_empty", e1, e2, 256'h1);
        consume("rp_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xoodyak_hash_ctrl.md
# xoodyak_hash_ctrl

Sequencing controller that sits directly upstream of `permute`. It runs the Xoodyak Cyclist hash mode: it absorbs message blocks through a valid/ready handshake, applies the Down padding and domain constants to a 384-bit state register, and launches `permute` for every Up. It then squeezes a 256-bit digest. The block owns the only copy of the state; `permute` is used purely as a 12-cycle compute engine.

## Interface
Parameters:
- `RATE_BYTES`, 16: hash absorb/squeeze rate in bytes. Fixed for hash mode; not to be overridden.

Ports:
- `eph1`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `msg_valid`  in  1  message block offered.
- `msg_ready`  out  1  block accepted on the `msg_valid & msg_ready` edge.
- `msg_data`  in  128  block bytes; byte i at [8i+7:8i].
- `msg_len`  in  5  valid bytes, 0..16; values >16 are treated as 16.
- `msg_last`  in  1  final block of the message.
- `perm_start`  out  1  one-cycle pulse to `permute.start`.
- `perm_state_in`  out  384  state to `permute`; state byte i at [8i+7:8i]. Equals the state register at all times.
- `perm_state_out`  in  384  `permute` result, same byte order.
- `perm_done`  in  1  `permute.xood_done`.
- `dig_valid`  out  1  digest available.
- `dig_ready`  in  1  digest consumed.
- `dig_data`  out  256  digest; [127:0] = first squeeze, [255:128] = second squeeze.
- `busy`  out  1  high in SQZ or PERM.

## Operation
- Registers:
  - `st[383:0]`, the state.
  - `first`, high until the first Down of a message.
  - `fsm`, one of ABSORB, SQZ, PERM, OUT.
  - `ret`, one of RA (return to absorb), RM (mid-squeeze), RO (return to output).
  - `started`.
  - `dig_lo`, `dig_hi`.
- Reset (`reset`=0 at an edge):
  - `st`=0, `first`=1, `fsm`=ABSORB, `started`=0, `dig_lo`=`dig_hi`=0.
  - While `reset`=0, every output is 0: `msg_ready`, `perm_start`, `perm_state_in`, `dig_valid`, `dig_data`, `busy`.
- ABSORB:
  - `msg_ready`=1.
  - On handshake, apply Down with n = `msg_len`:
    - `st` bytes 0..n-1 ^= `msg_data` bytes.
    - byte n ^= 0x01.
    - byte 47 ^= (`first` ? 0x03 : 0x00).
  - Then clear `first`.
  - If `msg_last`, go to SQZ; otherwise go to PERM with `ret`=RA.
- SQZ: lasts one cycle. Byte 47 ^= 0x40 (Cu for the first squeeze), then go to PERM with `ret`=RM.
- PERM:
  - `perm_start`=1 only in the first cycle after entry, while `started`=0. `started` sets on that cycle.
  - `perm_state_in` stays stable for the whole state.
  - `perm_done` is ignored in the start cycle.
  - On `perm_done`, `st` takes `perm_state_out` and `started` clears. Then, by `ret`:
    - RA: go to ABSORB.
    - RM: `dig_lo` takes `perm_state_out[127:0]`, byte 0 ^= 0x01 (Down of the empty string, Cd=0), and PERM is re-entered with `ret`=RO, so a new start fires on the next cycle.
    - RO: `dig_hi` takes `perm_state_out[127:0]`, then go to OUT.
- OUT:
  - `dig_valid`=1 and `dig_data` stays stable until `dig_ready`.
  - On handshake: `st`=0, `first`=1, go to ABSORB.
  - `dig_data` holds its value until the next digest overwrites it.
- `perm_done` outside a started PERM is ignored.
- A zero-length block is legal with either value of `msg_last`; it contributes padding only.

## Timing
- `permute` latency: with `perm_start` at cycle S, `perm_done` and a valid `perm_state_out` arrive at S+12. `st` must be stable over S..S+1, since `permute` samples it at S+1.
- Non-last block accepted at cycle T:
  - PERM start at T+1.
  - done at T+13.
  - `msg_ready`=1 again at T+14.
- Last block accepted at T:
  - SQZ at T+1.
  - start at T+2, done at T+14.
  - second start at T+15, done at T+27.
  - `dig_valid`=1 from T+28.
- A reset in any state takes effect at the next edge; the sequence in progress is discarded. A stale `perm_done` is harmless because a new start reloads `permute`.
- `msg_valid`, `dig_ready` and `perm_done` must all be driven by registered logic.

## Test plan
- Empty message, using an identity permute stub with 12-cycle done:
  - Stimulus: `msg_len`=0, `msg_last`=1.
  - At the first `perm_start`: `perm_state_in[7:0]`=0x01 and `[383:376]`=0x43.
  - Result: `dig_data`=256'h1 at T+28.
- Single 16-byte block 0x0F..0x00 (byte i = i), `msg_last`=1, identity stub:
  - First-start state: byte16=0x01, byte47=0x43.
  - `dig_lo`=128'h0F0E..0100.
  - `dig_hi` identical except byte0=0x01.
- Two blocks, the first non-last:
  - `msg_ready` low for T+1..T+13 and high at T+14.
  - The second Down leaves byte 47 at 0x03 (Cd=0).
- `dig_ready` held low for 20 cycles: `dig_valid` and `dig_data` stay constant, and `msg_ready` stays 0.
- Reset at cycle T+6 of a PERM: all outputs are 0 during reset.
  - A stray `perm_done` injected in ABSORB is ignored.
  - The next message produces the same digest as from cold.
- Integration with the real `permute`: 1-, 16-, 17- and 47-byte messages match the Xoodyak software model digest.
